// File: rtl/fractal_pkg.sv
// Shared types and constants for the fractal colorizer: pixel/RGB structs,
// sync FSM states and the grayscale helper used for the palette power-up image.
package fractal_pkg;

  localparam logic [7:0] MAX_ITER = 8'd255;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  typedef struct packed {
    rgb_t rgb;
    logic user;
    logic last;
  } pix_t;

  typedef enum logic {
    WAIT_SOF = 1'b0,
    RUN      = 1'b1
  } sync_state_t;

  function automatic rgb_t gray(input logic [7:0] v);
    rgb_t c;
    c.r = v;
    c.g = v;
    c.b = v;
    return c;
  endfunction

endpackage

// File: rtl/fractal_colorizer_if.sv
// AXI4-Stream RGB video link from the colorizer towards the video DMA.
interface fractal_colorizer_if;

  logic [23:0] tdata;
  logic        tuser;
  logic        tlast;
  logic        tvalid;
  logic        tready;

  modport master (output tdata, output tuser, output tlast, output tvalid, input tready);
  modport slave  (input tdata, input tuser, input tlast, input tvalid, output tready);

endinterface

// File: rtl/fractal_stream_fifo.sv
// Synchronous first-word-fall-through FIFO of pix_t with registered full/empty.
// Push and pop in the same cycle are accepted even when full.
module fractal_stream_fifo
  import fractal_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  pix_t din,
  output logic full,
  input  logic pop,
  output pix_t dout,
  output logic empty
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = AW + 1;

  pix_t           mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_nxt;
  logic           do_push;
  logic           do_pop;

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_comb begin
    count_nxt = count;
    if (do_push && !do_pop) begin
      count_nxt = count + 1'b1;
    end else if (!do_push && do_pop) begin
      count_nxt = count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_nxt;
      full  <= (count_nxt == CNT_W'(DEPTH));
      empty <= (count_nxt == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/fractal_colorizer.sv
// Maps the fractal generator's iteration stream to RGB through a writable
// palette and streams it out over AXI4-Stream. Colour cycling: FRACTAL_COLORIZER_ROTATE_EN.
//
// state    | meaning
// WAIT_SOF | discard pixels until a frame_start pixel can be pushed
// RUN      | push every pixel; a drop for full returns to WAIT_SOF
module fractal_colorizer
  import fractal_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter logic [7:0]  MAX_ITER   = fractal_pkg::MAX_ITER
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  s_data,
  input  logic        s_frame_start,
  input  logic        s_line_end,
  input  logic        s_valid,
  input  logic        pal_we,
  input  logic [7:0]  pal_addr,
  input  logic [23:0] pal_wdata,
  input  logic        rotate_en,
  fractal_colorizer_if.master m_axis,
  output logic        overflow
);

  logic [7:0] cur_off;

`ifdef FRACTAL_COLORIZER_ROTATE_EN
  logic [7:0] offset;
  logic [7:0] frame_off;

  // The frame_start pixel samples the live offset; the rest of the frame
  // reuses that value so one frame never mixes two offsets.
  always_ff @(posedge clk) begin
    if (reset) begin
      offset    <= '0;
      frame_off <= '0;
    end else if (s_valid && s_frame_start) begin
      frame_off <= offset;
      if (rotate_en) offset <= offset + 1'b1;
    end
  end

  assign cur_off = s_frame_start ? offset : frame_off;
`else
  logic unused_rotate;
  assign unused_rotate = rotate_en;
  assign cur_off       = 8'd0;
`endif

  logic        s1_valid, s2_valid, s3_valid;
  logic [7:0]  s1_iter, s2_iter;
  logic [7:0]  s1_idx, s2_idx;
  logic        s1_user, s2_user;
  logic        s1_last, s2_last;
  logic [23:0] pal_q;
  pix_t        s3_pix;
  logic [23:0] pal_ram [256];

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s3_valid <= 1'b0;
    end else begin
      s1_valid <= s_valid;
      s2_valid <= s1_valid;
      s3_valid <= s2_valid;
    end
  end

  always_ff @(posedge clk) begin
    s1_iter <= s_data;
    s1_idx  <= s_data + cur_off;
    s1_user <= s_frame_start;
    s1_last <= s_line_end;
    s2_iter <= s1_iter;
    s2_idx  <= s1_idx;
    s2_user <= s1_user;
    s2_last <= s1_last;
  end

  // Entries are stored XORed with {i,i,i}, so a zero power-up RAM reads back
  // as grayscale without any initialisation logic. Read-first on collision.
  always_ff @(posedge clk) begin
    if (pal_we) pal_ram[pal_addr] <= pal_wdata ^ gray(pal_addr);
    pal_q <= pal_ram[s1_idx];
  end

  always_ff @(posedge clk) begin
    s3_pix.rgb  <= (s2_iter == MAX_ITER) ? rgb_t'(24'h0) : rgb_t'(pal_q ^ gray(s2_idx));
    s3_pix.user <= s2_user;
    s3_pix.last <= s2_last;
  end

  logic        fifo_push;
  logic        fifo_pop;
  logic        fifo_full;
  logic        fifo_empty;
  pix_t        fifo_dout;
  logic        drop;
  logic        accept;
  sync_state_t state, state_nxt;

  assign fifo_pop = !fifo_empty && m_axis.tready;
  assign accept   = !fifo_full || fifo_pop;

  always_ff @(posedge clk) begin
    if (reset) state <= WAIT_SOF;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    fifo_push = 1'b0;
    drop      = 1'b0;
    if (s3_valid) begin
      case (state)
        WAIT_SOF: begin
          if (s3_pix.user) begin
            if (accept) begin
              fifo_push = 1'b1;
              state_nxt = RUN;
            end else begin
              drop = 1'b1;
            end
          end
        end
        RUN: begin
          if (accept) begin
            fifo_push = 1'b1;
          end else begin
            drop      = 1'b1;
            state_nxt = WAIT_SOF;
          end
        end
        default: state_nxt = WAIT_SOF;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset)     overflow <= 1'b0;
    else if (drop) overflow <= 1'b1;
  end

  fractal_stream_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .din   (s3_pix),
    .full  (fifo_full),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .empty (fifo_empty)
  );

  // Gate the FIFO head so the bus reads all-zero while nothing is buffered.
  assign m_axis.tvalid = !fifo_empty;
  assign m_axis.tdata  = fifo_empty ? 24'h0 : fifo_dout.rgb;
  assign m_axis.tuser  = !fifo_empty && fifo_dout.user;
  assign m_axis.tlast  = !fifo_empty && fifo_dout.last;

endmodule

// File: tb/tb_fractal_colorizer.sv
// Directed self-checking bench for fractal_colorizer: palette mapping, latency,
// frame resync after overflow, push/pop at full and colour rotation.
module tb_fractal_colorizer;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  s_data;
  logic        s_frame_start;
  logic        s_line_end;
  logic        s_valid;
  logic        pal_we;
  logic [7:0]  pal_addr;
  logic [23:0] pal_wdata;
  logic        rotate_en;
  logic        overflow;

  fractal_colorizer_if axis_if ();

  fractal_colorizer #(
    .FIFO_DEPTH (16),
    .MAX_ITER   (8'd255)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .s_data        (s_data),
    .s_frame_start (s_frame_start),
    .s_line_end    (s_line_end),
    .s_valid       (s_valid),
    .pal_we        (pal_we),
    .pal_addr      (pal_addr),
    .pal_wdata     (pal_wdata),
    .rotate_en     (rotate_en),
    .m_axis        (axis_if),
    .overflow      (overflow)
  );

  always #5 clk = ~clk;

  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;
  logic [25:0] cap [$];
  int          cap_cyc [$];
  logic [25:0] exp_q [$];
  logic [23:0] tb_pal [256];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!reset && axis_if.tvalid && axis_if.tready) begin
      cap.push_back({axis_if.tuser, axis_if.tlast, axis_if.tdata});
      cap_cyc.push_back(cyc);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] exp_rgb(input logic [7:0] d);
    return (d == 8'hFF) ? 24'h0 : tb_pal[d];
  endfunction

  task automatic add_exp(input logic [7:0] d, input logic u, input logic l);
    exp_q.push_back({u, l, exp_rgb(d)});
  endtask

  task automatic drive_px(input logic [7:0] d, input logic sof, input logic eol);
    @(posedge clk); #1;
    s_data        = d;
    s_frame_start = sof;
    s_line_end    = eol;
    s_valid       = 1'b1;
  endtask

  task automatic idle();
    @(posedge clk); #1;
    s_valid       = 1'b0;
    s_frame_start = 1'b0;
    s_line_end    = 1'b0;
    pal_we        = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset   = 1'b1;
    s_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    cap.delete();
    cap_cyc.delete();
  endtask

  task automatic check_beats(input string tag);
    int n;
    int budget;
    n = exp_q.size();
    budget = 300;
    while (cap.size() < n && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    repeat (6) @(posedge clk);
    chk({tag, "_count"}, cap.size(), n);
    for (int i = 0; i < n && i < cap.size(); i++)
      chk($sformatf("%s_beat%0d", tag, i), {6'b0, cap[i]}, {6'b0, exp_q[i]});
    cap.delete();
    cap_cyc.delete();
    exp_q.delete();
  endtask

  initial begin
    int start_cyc;
    int budget;
    for (int i = 0; i < 256; i++) tb_pal[i] = {8'(i), 8'(i), 8'(i)};
    reset = 1'b1; s_data = '0; s_frame_start = 1'b0; s_line_end = 1'b0; s_valid = 1'b0;
    pal_we = 1'b0; pal_addr = '0; pal_wdata = '0; rotate_en = 1'b0; axis_if.tready = 1'b1;

    // Reset state, sampled while reset is still held
    repeat (2) @(posedge clk);
    #1;
    chk("rst_tvalid", axis_if.tvalid, 0);
    chk("rst_tdata", axis_if.tdata, 0);
    chk("rst_tuser", axis_if.tuser, 0);
    chk("rst_tlast", axis_if.tlast, 0);
    chk("rst_overflow", overflow, 0);
    @(posedge clk); #1 reset = 1'b0;

    // 4x2 frame with default grayscale palette, plus latency
    for (int k = 0; k < 8; k++) begin
      drive_px(8'(k), k == 0, (k % 4) == 3);
      if (k == 0) start_cyc = cyc;
      add_exp(8'(k), k == 0, (k % 4) == 3);
    end
    idle();
    budget = 50;
    while (cap.size() == 0 && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    chk("latency", (cap_cyc.size() > 0) ? cap_cyc[0] - start_cyc : -1, 4);
    check_beats("frame4x2");

    // Palette write, MAX_ITER bypass
    @(posedge clk); #1;
    pal_we = 1'b1; pal_addr = 8'd5; pal_wdata = 24'hFF8000;
    idle();
    tb_pal[5] = 24'hFF8000;
    drive_px(8'd5, 1'b1, 1'b0);
    add_exp(8'd5, 1'b1, 1'b0);
    drive_px(8'd255, 1'b0, 1'b1);
    add_exp(8'd255, 1'b0, 1'b1);
    idle();
    check_beats("pal_write");

    // Write colliding with a read of the same entry returns the old entry
    drive_px(8'd6, 1'b1, 1'b0);
    drive_px(8'd6, 1'b0, 1'b1);
    pal_we = 1'b1; pal_addr = 8'd6; pal_wdata = 24'h123456;
    add_exp(8'd6, 1'b1, 1'b0);
    tb_pal[6] = 24'h123456;
    add_exp(8'd6, 1'b0, 1'b1);
    idle();
    check_beats("read_first");

    // Reset: pixels before first frame_start are discarded; palette survives
    do_reset();
    chk("rst2_overflow", overflow, 0);
    drive_px(8'd1, 1'b0, 1'b0);
    drive_px(8'd2, 1'b0, 1'b0);
    drive_px(8'd3, 1'b0, 1'b1);
    idle();
    repeat (3) @(posedge clk);
    drive_px(8'd5, 1'b1, 1'b0);
    add_exp(8'd5, 1'b1, 1'b0);
    drive_px(8'd11, 1'b0, 1'b1);
    add_exp(8'd11, 1'b0, 1'b1);
    idle();
    check_beats("presof");

    // Overflow with tready low, then resync on the next frame
    axis_if.tready = 1'b0;
    for (int k = 0; k < 32; k++) begin
      drive_px(8'(k), k == 0, (k % 4) == 3);
      if (k < 16) add_exp(8'(k), k == 0, (k % 4) == 3);
    end
    idle();
    repeat (10) @(posedge clk);
    #1;
    chk("ovf_set", overflow, 1);
    chk("ovf_held_valid", axis_if.tvalid, 1);
    chk("ovf_no_beats", cap.size(), 0);
    axis_if.tready = 1'b1;
    repeat (4) @(posedge clk);
    for (int k = 0; k < 8; k++) begin
      drive_px(8'(100 + k), k == 0, (k % 4) == 3);
      add_exp(8'(100 + k), k == 0, (k % 4) == 3);
    end
    idle();
    check_beats("resync");
    chk("ovf_sticky", overflow, 1);

    // Push at full with a simultaneous pop: nothing dropped
    do_reset();
    axis_if.tready = 1'b0;
    for (int k = 0; k < 20; k++) begin
      drive_px(8'(32 + k), k == 0, (k % 4) == 3);
      if (k == 19) axis_if.tready = 1'b1;
      add_exp(8'(32 + k), k == 0, (k % 4) == 3);
    end
    idle();
    check_beats("full_pushpop");
    chk("full_pushpop_ovf", overflow, 0);

    // Colour rotation over three single-pixel frames
    rotate_en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      drive_px(8'd0, 1'b1, 1'b1);
`ifdef FRACTAL_COLORIZER_ROTATE_EN
      exp_q.push_back({1'b1, 1'b1, tb_pal[k]});
`else
      exp_q.push_back({1'b1, 1'b1, tb_pal[0]});
`endif
    end
    idle();
    rotate_en = 1'b0;
    check_beats("rotate");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
